// File: rtl/phy_clk_ratio_monitor.sv
// PHY clock ratio monitor: measures Word_CLK and PCLK periods in Bit_CLK cycles,
// checks them against the expected ratios and reports lock, error pulses and an error count.

module phy_clk_ratio_chan #(
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             mon_clk,
    input  logic [CNT_W-1:0] exp_period,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] period
);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIDE_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              lock_d, err_d;
    logic [CNT_W-1:0]  period_d;
    logic              edge_c, good_c, timeout_c;
    logic [WIDE_W-1:0] cnt_w, exp_w, tol_w;

    assign edge_c    = sync2_q & ~prev_q;
    assign cnt_w     = WIDE_W'(cnt_q);
    assign exp_w     = WIDE_W'(exp_period);
    assign tol_w     = WIDE_W'(TOL);
    assign good_c    = ((cnt_w + tol_w) >= exp_w) && (cnt_w <= (exp_w + tol_w));
    assign timeout_c = !edge_c && (cnt_w == (exp_w + tol_w));

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        lock_d   = lock;
        err_d    = 1'b0;
        period_d = period;
        if (!en) begin
            state_d = IDLE;
            good_d  = '0;
            lock_d  = 1'b0;
        end else if (restart) begin
            state_d = ACQUIRE;
            good_d  = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    lock_d  = 1'b0;
                end
                ACQUIRE: begin
                    if (edge_c) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (edge_c) begin
                        period_d = cnt_q;
                        if (good_c) begin
                            if (state_q == MEASURE) begin
                                if ((good_q + GOOD_W'(1)) == GOOD_W'(LOCK_CNT)) begin
                                    state_d = LOCKED;
                                    lock_d  = 1'b1;
                                    good_d  = '0;
                                end else begin
                                    good_d = good_q + GOOD_W'(1);
                                end
                            end
                        end else begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            lock_d  = 1'b0;
                            state_d = MEASURE;
                        end
                    end else if (timeout_c) begin
                        // late edge will be treated as a fresh first edge in ACQUIRE
                        err_d   = 1'b1;
                        good_d  = '0;
                        lock_d  = 1'b0;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            good_q  <= '0;
            lock    <= 1'b0;
            err     <= 1'b0;
            period  <= '0;
        end else begin
            sync1_q <= mon_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (edge_c) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            state_q <= state_d;
            good_q  <= good_d;
            lock    <= lock_d;
            err     <= err_d;
            period  <= period_d;
        end
    end
endmodule

module phy_clk_ratio_monitor #(
    parameter int unsigned WORD_RATIO = 10,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERRCNT_W   = 16
) (
    input  logic                Bit_CLK,
    input  logic                Rst,
    input  logic                Mon_En,
    input  logic                Word_CLK,
    input  logic                PCLK,
    input  logic [5:0]          DataBusWidth,
    output logic                Word_Lock,
    output logic                PCLK_Lock,
    output logic                Word_Err,
    output logic                PCLK_Err,
    output logic [CNT_W-1:0]    Word_Period,
    output logic [CNT_W-1:0]    PCLK_Period,
    output logic [ERRCNT_W-1:0] Err_Count,
    output logic                Cfg_Err
);
    logic [5:0]          width_q, width_q2;
    logic                width_valid_c, pclk_restart_c, pclk_en_c;
    logic [CNT_W-1:0]    word_exp_c, pclk_exp_c;
    logic [ERRCNT_W:0]   err_sum_c;

    function automatic logic width_ok(input logic [5:0] w);
        return (w == 6'd8) || (w == 6'd16) || (w == 6'd32);
    endfunction

    assign width_valid_c  = width_ok(width_q);
    assign pclk_restart_c = width_valid_c && (width_q != width_q2);
    assign pclk_en_c      = Mon_En && width_valid_c;
    assign word_exp_c     = CNT_W'(WORD_RATIO);

    // Expected PCLK period scales with the PIPE data width
    always_comb begin
        pclk_exp_c = CNT_W'(WORD_RATIO);
        case (width_q)
            6'd16:   pclk_exp_c = CNT_W'(WORD_RATIO * 2);
            6'd32:   pclk_exp_c = CNT_W'(WORD_RATIO * 4);
            default: pclk_exp_c = CNT_W'(WORD_RATIO);
        endcase
    end

    assign err_sum_c = (ERRCNT_W + 1)'(Err_Count) + (ERRCNT_W + 1)'(Word_Err)
                     + (ERRCNT_W + 1)'(PCLK_Err);

    always_ff @(posedge Bit_CLK) begin
        if (Rst) begin
            width_q   <= '0;
            width_q2  <= '0;
            Cfg_Err   <= 1'b0;
            Err_Count <= '0;
        end else begin
            width_q  <= DataBusWidth;
            width_q2 <= width_q;
            Cfg_Err  <= !width_ok(DataBusWidth);
            if (err_sum_c[ERRCNT_W]) begin
                Err_Count <= '1;
            end else begin
                Err_Count <= err_sum_c[ERRCNT_W-1:0];
            end
        end
    end

    phy_clk_ratio_chan #(.TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_word (
        .clk        (Bit_CLK),
        .rst        (Rst),
        .en         (Mon_En),
        .restart    (1'b0),
        .mon_clk    (Word_CLK),
        .exp_period (word_exp_c),
        .lock       (Word_Lock),
        .err        (Word_Err),
        .period     (Word_Period)
    );

    phy_clk_ratio_chan #(.TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_pclk (
        .clk        (Bit_CLK),
        .rst        (Rst),
        .en         (pclk_en_c),
        .restart    (pclk_restart_c),
        .mon_clk    (PCLK),
        .exp_period (pclk_exp_c),
        .lock       (PCLK_Lock),
        .err        (PCLK_Err),
        .period     (PCLK_Period)
    );
endmodule

// File: tb/tb_phy_clk_ratio_monitor.sv
// Self-checking bench for phy_clk_ratio_monitor: scheduled clock edges checked against a period-list model.

module tb_phy_clk_ratio_monitor;
    localparam int unsigned WR       = 10;
    localparam int unsigned TOL      = 0;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned ERRCNT_W = 4;

    logic                Bit_CLK = 1'b0;
    logic                Rst = 1'b1;
    logic                Mon_En = 1'b0;
    logic                Word_CLK = 1'b0;
    logic                PCLK = 1'b0;
    logic [5:0]          DataBusWidth = 6'd16;
    logic                Word_Lock, PCLK_Lock, Word_Err, PCLK_Err, Cfg_Err;
    logic [CNT_W-1:0]    Word_Period, PCLK_Period;
    logic [ERRCNT_W-1:0] Err_Count;

    phy_clk_ratio_monitor #(.WORD_RATIO(WR), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
                            .CNT_W(CNT_W), .ERRCNT_W(ERRCNT_W)) dut (
        .Bit_CLK(Bit_CLK), .Rst(Rst), .Mon_En(Mon_En), .Word_CLK(Word_CLK), .PCLK(PCLK),
        .DataBusWidth(DataBusWidth), .Word_Lock(Word_Lock), .PCLK_Lock(PCLK_Lock),
        .Word_Err(Word_Err), .PCLK_Err(PCLK_Err), .Word_Period(Word_Period),
        .PCLK_Period(PCLK_Period), .Err_Count(Err_Count), .Cfg_Err(Cfg_Err)
    );

    always #5 Bit_CLK = ~Bit_CLK;

    int checks = 0;
    int errors = 0;
    int w_iv[$], p_iv[$], w_r[$], p_r[$];
    int w_last, p_last, w_errs, p_errs, both_errs;
    logic w_lock_s, p_lock_s;
    logic [CNT_W-1:0] w_per_s, p_per_s;
    logic [ERRCNT_W-1:0] ec_s;

    // Reference: walk the list of intervals between rising edges using the lock/error rules
    task automatic model(input int iv[$], input int exp_p, input bit tail_to,
                         output int errs, output bit lk, output int per);
        int good;
        errs = 0; lk = 1'b0; per = 0; good = 0;
        foreach (iv[i]) begin
            if (iv[i] > exp_p + int'(TOL)) begin
                errs++; good = 0; lk = 1'b0;
            end else begin
                per = iv[i];
                if (iv[i] + int'(TOL) >= exp_p) begin
                    if (!lk) begin
                        good++;
                        if (good >= int'(LOCK_CNT)) lk = 1'b1;
                    end
                end else begin
                    errs++; good = 0; lk = 1'b0;
                end
            end
        end
        if (tail_to) errs++;
    endtask

    function automatic logic level_at(input int r[$], input int t);
        int gap, hi;
        for (int k = 0; k < r.size(); k++) begin
            gap = (k + 1 < r.size()) ? r[k+1] - r[k] : 10;
            hi  = (gap >= 50) ? gap - 4 : gap / 2;
            if (t >= r[k] && t < r[k] + hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int sat(input int v);
        return (v > (1 << ERRCNT_W) - 1) ? (1 << ERRCNT_W) - 1 : v;
    endfunction

    task automatic do_reset(input logic [5:0] w);
        @(negedge Bit_CLK);
        Rst = 1'b1; Mon_En = 1'b1; DataBusWidth = w; Word_CLK = 1'b0; PCLK = 1'b0;
        repeat (3) @(negedge Bit_CLK);
        Rst = 1'b0;
    endtask

    task automatic run(input int w_off, input int p_off, input int tail,
                       input int tw, input logic [5:0] wv, input int te);
        int t_end;
        w_r.delete(); p_r.delete();
        if (w_off >= 0) begin
            w_r.push_back(w_off);
            foreach (w_iv[i]) w_r.push_back(w_r[$] + w_iv[i]);
        end
        if (p_off >= 0) begin
            p_r.push_back(p_off);
            foreach (p_iv[i]) p_r.push_back(p_r[$] + p_iv[i]);
        end
        w_last = (w_r.size() > 0) ? w_r[$] : -100;
        p_last = (p_r.size() > 0) ? p_r[$] : -100;
        t_end  = ((w_last > p_last) ? w_last : p_last) + tail;
        w_errs = 0; p_errs = 0; both_errs = 0;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge Bit_CLK);
            if (Word_Err === 1'b1) w_errs++;
            if (PCLK_Err === 1'b1) p_errs++;
            if (Word_Err === 1'b1 && PCLK_Err === 1'b1) both_errs++;
            if (t == w_last + 6) begin
                w_lock_s = Word_Lock; w_per_s = Word_Period; ec_s = Err_Count;
            end
            if (t == p_last + 6) begin
                p_lock_s = PCLK_Lock; p_per_s = PCLK_Period;
            end
            Word_CLK = level_at(w_r, t);
            PCLK     = level_at(p_r, t);
            if (t == tw) DataBusWidth = wv;
            if (t == te) Mon_En = 1'b0;
        end
    endtask

    task automatic check_chan(input string name, input bit is_word, input int m_errs,
                              input bit m_lk, input int m_per);
        logic lk; logic [CNT_W-1:0] per; int ec;
        lk  = is_word ? w_lock_s : p_lock_s;
        per = is_word ? w_per_s : p_per_s;
        ec  = is_word ? w_errs : p_errs;
        checks++;
        if (lk !== m_lk) begin
            errors++; $display("FAIL %s lock got %b want %b", name, lk, m_lk);
        end
        checks++;
        if (per !== CNT_W'(m_per)) begin
            errors++; $display("FAIL %s period got %0d want %0d", name, per, m_per);
        end
        checks++;
        if (ec != m_errs) begin
            errors++; $display("FAIL %s err_pulses got %0d want %0d", name, ec, m_errs);
        end
    endtask

    task automatic check_errcnt(input string name, input int want);
        checks++;
        if (Err_Count !== ERRCNT_W'(sat(want))) begin
            errors++; $display("FAIL %s Err_Count got %0d want %0d", name, Err_Count, sat(want));
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({Word_Lock, PCLK_Lock, Word_Err, PCLK_Err, Cfg_Err} !== 5'b0 ||
            Word_Period !== '0 || PCLK_Period !== '0 || Err_Count !== '0) begin
            errors++;
            $display("FAIL %s outputs got lk=%b%b err=%b%b cfg=%b wp=%0d pp=%0d ec=%0d want all 0",
                     name, Word_Lock, PCLK_Lock, Word_Err, PCLK_Err, Cfg_Err,
                     Word_Period, PCLK_Period, Err_Count);
        end
    endtask

    task automatic test_reset();
        do_reset(6'd16);
        #1;
        check_all_zero("reset");
    endtask

    task automatic test_lock();
        int we, pe, wp, pp; bit wl, pl;
        do_reset(6'd16);
        w_iv = {10, 10, 10, 10, 10, 10};
        p_iv = {20, 20, 20, 20, 20};
        run(4, 4, 70, -1, 6'd16, -1);
        model(w_iv, WR, 1, we, wl, wp);
        model(p_iv, 2 * WR, 1, pe, pl, pp);
        check_chan("lock_word", 1, we, wl, wp);
        check_chan("lock_pclk", 0, pe, pl, pp);
        checks++;
        if (ec_s !== '0) begin
            errors++; $display("FAIL lock_errcnt got %0d want 0", ec_s);
        end
    endtask

    task automatic test_word_err();
        int we, pe, wp, pp; bit wl, pl;
        do_reset(6'd16);
        w_iv = {10, 10, 10, 10, 10, 11, 10, 10, 10, 10, 10};
        p_iv = {20, 20, 20, 20};
        run(4, 6, 70, -1, 6'd16, -1);
        model(w_iv, WR, 1, we, wl, wp);
        model(p_iv, 2 * WR, 1, pe, pl, pp);
        check_chan("word_err_word", 1, we, wl, wp);
        check_chan("word_err_pclk", 0, pe, pl, pp);
        check_errcnt("word_err", we + pe);
    endtask

    task automatic test_pclk_stop();
        int we, pe, wp, pp; bit wl, pl;
        do_reset(6'd16);
        w_iv = {};
        p_iv = {20, 20, 20, 20, 20, 70, 20, 20, 20, 20, 20};
        run(-1, 4, 70, -1, 6'd16, -1);
        model(p_iv, 2 * WR, 1, pe, pl, pp);
        check_chan("pclk_stop", 0, pe, pl, pp);
        check_errcnt("pclk_stop", pe);
    endtask

    task automatic test_width_change();
        int q1[$], q2[$];
        int e1, e2, we, wp, p1, p2; bit l1, l2, wl;
        do_reset(6'd16);
        q1 = {20, 20, 20, 20, 20};
        q2 = {40, 40, 40, 40, 40, 40};
        p_iv = {q1, 15, q2};
        w_iv = {};
        for (int i = 0; i < 36; i++) w_iv.push_back(10);
        run(4, 4, 120, 4 + 100 + 5, 6'd32, -1);
        model(q1, 2 * WR, 0, e1, l1, p1);
        model(q2, 4 * WR, 1, e2, l2, p2);
        model(w_iv, WR, 1, we, wl, wp);
        check_chan("width_chg_pclk", 0, e1 + e2, l2, p2);
        check_chan("width_chg_word", 1, we, wl, wp);
    endtask

    task automatic test_cfg_err();
        int we, wp; bit wl;
        do_reset(6'd16);
        w_iv = {};
        for (int i = 0; i < 30; i++) w_iv.push_back(10);
        p_iv = {20, 20, 20, 20, 20, 20, 20, 20, 20, 20};
        run(4, 4, 40, 4 + 120 + 3, 6'd12, -1);
        model(w_iv, WR, 1, we, wl, wp);
        check_chan("cfg_word", 1, we, wl, wp);
        checks++;
        if (Cfg_Err !== 1'b1 || PCLK_Lock !== 1'b0 || p_lock_s !== 1'b0 || p_errs != 0) begin
            errors++;
            $display("FAIL cfg_invalid got cfg=%b plock=%b/%b perr=%0d want 1 0/0 0",
                     Cfg_Err, PCLK_Lock, p_lock_s, p_errs);
        end
        DataBusWidth = 6'd16;
        repeat (3) @(negedge Bit_CLK);
        checks++;
        if (Cfg_Err !== 1'b0) begin
            errors++; $display("FAIL cfg_clear got %b want 0", Cfg_Err);
        end
    endtask

    task automatic test_mon_en();
        int we, pe, wp, pp; bit wl, pl;
        do_reset(6'd16);
        w_iv = {10, 8, 10, 10, 10, 10, 10, 10};
        p_iv = {20, 20, 20, 20};
        run(4, 4, 10, -1, 6'd16, 92);
        model(w_iv, WR, 0, we, wl, wp);
        model(p_iv, 2 * WR, 0, pe, pl, pp);
        check_chan("mon_en_word", 1, we, wl, wp);
        check_chan("mon_en_pclk", 0, pe, pl, pp);
        checks++;
        if (Word_Lock !== 1'b0 || PCLK_Lock !== 1'b0) begin
            errors++; $display("FAIL mon_en_off lock got %b%b want 00", Word_Lock, PCLK_Lock);
        end
        check_errcnt("mon_en_retain", we + pe);
    endtask

    task automatic test_random();
        logic [5:0] w; int exp_p, r, we, pe, wp, pp; bit wl, pl;
        for (int it = 0; it < 4; it++) begin
            r = int'($urandom_range(0, 2));
            w = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : 6'd32;
            exp_p = int'(WR) * (int'(w) / 8);
            do_reset(w);
            w_iv = {}; p_iv = {};
            for (int i = 0; i < 25; i++) begin
                r = int'($urandom_range(0, 11));
                w_iv.push_back(r == 0 ? 8 : r == 1 ? 9 : r == 2 ? 13 : r == 3 ? 25 : 10);
                r = int'($urandom_range(0, 9));
                p_iv.push_back(r == 0 ? exp_p - 2 : r == 1 ? exp_p + 1 : r == 2 ? exp_p + 7 : exp_p);
            end
            run(int'($urandom_range(3, 12)), int'($urandom_range(3, 12)), 4 * exp_p + 20,
                -1, w, -1);
            model(w_iv, WR, 1, we, wl, wp);
            model(p_iv, exp_p, 1, pe, pl, pp);
            check_chan("rand_word", 1, we, wl, wp);
            check_chan("rand_pclk", 0, pe, pl, pp);
            check_errcnt("rand", we + pe);
        end
    endtask

    task automatic test_saturate();
        int we, pe, wp, pp; bit wl, pl;
        do_reset(6'd16);
        w_iv = {};
        for (int i = 0; i < 14; i++) w_iv.push_back(8);
        p_iv = {20, 20, 20, 20, 20};
        run(4, 6, 70, -1, 6'd16, -1);
        model(w_iv, WR, 0, we, wl, wp);
        model(p_iv, 2 * WR, 0, pe, pl, pp);
        checks++;
        if (ec_s !== ERRCNT_W'(sat(we + pe))) begin
            errors++; $display("FAIL sat_before got %0d want %0d", ec_s, sat(we + pe));
        end
        checks++;
        if (both_errs != 1) begin
            errors++; $display("FAIL sat_simultaneous got %0d want 1", both_errs);
        end
        check_errcnt("sat_after", we + pe + 2);
        // reset while channels are active and the counter is saturated
        Word_CLK = 1'b1;
        Rst = 1'b1;
        @(negedge Bit_CLK);
        check_all_zero("rst_mid");
        Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_word_err();
        test_pclk_stop();
        test_width_change();
        test_cfg_err();
        test_mon_en();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/phy_clk_ratio_monitor.md
Name: phy_clk_ratio_monitor

Overview:
Synthesizable on-chip monitor for the PHY clock generator outputs. It runs on Bit_CLK and samples Word_CLK and PCLK as data. It measures each clock's period in Bit_CLK cycles and checks Word_CLK against WORD_RATIO and PCLK against WORD_RATIO*DataBusWidth/8. It reports lock, error pulses and a saturating error count to PHY status/debug logic.

Parameters:
WORD_RATIO, 10, expected Word_CLK period in Bit_CLK cycles (10b symbol)
TOL, 0, allowed |measured - expected| in Bit_CLK cycles
LOCK_CNT, 4, consecutive good periods required to assert lock
CNT_W, 8, width of period counters and period outputs
ERRCNT_W, 16, width of saturating error counter

Ports:
Bit_CLK  in  1  monitor clock, all logic on posedge
Rst  in  1  synchronous active-high reset
Mon_En  in  1  monitor enable; 0 forces both channels to IDLE
Word_CLK  in  1  monitored clock, sampled as data
PCLK  in  1  monitored clock, sampled as data
DataBusWidth  in  6  PIPE width: 8, 16 or 32
Word_Lock  out  1  Word_CLK channel locked
PCLK_Lock  out  1  PCLK channel locked
Word_Err  out  1  one-cycle pulse on Word_CLK period violation
PCLK_Err  out  1  one-cycle pulse on PCLK period violation
Word_Period  out  CNT_W  last measured Word_CLK period
PCLK_Period  out  CNT_W  last measured PCLK period
Err_Count  out  ERRCNT_W  saturating total of error pulses
Cfg_Err  out  1  DataBusWidth not in {8,16,32}

Behaviour:
- Reset: all outputs 0; both channel FSMs IDLE; counters 0; synchronizer flops 0.
- Per input: 2-flop synchronizer, then a prev flop. Edge = sync & ~prev. Edge is flagged 3 Bit_CLK cycles after the input rises.
- Counter cnt: on edge, cnt <= 1; otherwise cnt saturating-increments. The period is the cnt value seen on an edge.
- EXP: Word = WORD_RATIO; PCLK = WORD_RATIO*1/2/4 for width 8/16/32 (default 10/20/40).
- FSM per channel: IDLE, ACQUIRE, MEASURE, LOCKED.
- IDLE: outputs Lock=0. Go to ACQUIRE when Mon_En=1 (and, for PCLK only, width is valid).
- ACQUIRE: the first edge only restarts cnt, with no compare and no Period update. Then go to MEASURE with good_cnt=0.
- MEASURE and LOCKED, on edge:
  - Period <= cnt.
  - Good if |cnt-EXP| <= TOL.
  - In MEASURE, a good period increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED and Lock=1.
  - A bad period gives an Err pulse, good_cnt=0, and state MEASURE (Lock drops the next cycle).
- Timeout: in MEASURE or LOCKED, no edge while cnt==EXP+TOL gives an Err pulse, Lock=0 and state ACQUIRE. The late edge is then treated as a new first edge; there is no double error.
- Lock is registered: it rises on the cycle after the LOCK_CNT-th good edge.
- DataBusWidth is registered:
  - A change while valid sends the PCLK channel to ACQUIRE with Lock=0 and no Err. The Word channel is unaffected.
  - An invalid value sets Cfg_Err=1 (registered) and holds PCLK in IDLE. Cfg_Err clears when the value becomes valid.
- Mon_En=0: both channels go to IDLE next cycle, Lock=0, Err_Count retained.
- Err_Count: adds Word_Err+PCLK_Err each cycle (+2 if simultaneous) and saturates at all-ones. Only Rst clears it.
- Period outputs hold their last value until the next measured edge.

Test Plan:
- Rst, Mon_En=1, Word_CLK period 10 Bit_CLK, PCLK 20, width=16 -> both Lock=1 after 1+4 edges, Word_Period=10, PCLK_Period=20, Err_Count=0.
- Locked, one Word_CLK period of 11 (TOL=0) -> Word_Err single pulse, Word_Lock=0, relock after 4 good periods, Err_Count=1.
- Locked, PCLK stops high -> PCLK_Err pulse when cnt=20 with no edge, state ACQUIRE; on restart, relock with no extra error.
- Locked at width=16, switch to 32 with PCLK=40 -> PCLK_Lock drops, no PCLK_Err, relocks at 40.
- DataBusWidth=12 -> Cfg_Err=1, PCLK_Lock=0, no PCLK_Err; Word channel stays locked.
- Both channels fault in the same cycle with Err_Count=0xFFFE -> Err_Count=0xFFFF (saturated); Rst mid-measure -> all outputs 0 next cycle.
